fp_add_seq: RTL
===============

// Module: fp_add_seq
// PURPOSE
//  Multi-cycle sequencer for IEEE-754 single-precision add/sub around the adder_eac datapath.
//  - Accepts one operand pair per transaction (valid/ready); unpacks, swaps, aligns, adds, normalises and rounds.
//  - Result is round-to-nearest-even, returned on a valid/ready output; one operation in flight.
//  - Sits between the issue logic and the writeback stage of the FP adder.
// PARAMETERS
//  SIG_WIDTH  23  fraction width (from parameters.v); extended significand = SIG_WIDTH*2+3 = 49 b
//  EXP_WIDTH   8  exponent width (from parameters.v); bias = 2^(EXP_WIDTH-1)-1
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   sequencer can accept (state IDLE)
//  a, b       in   32  IEEE-754 operands
//  op         in   1   0 = a+b, 1 = a-b
//  out_valid  out  1   result valid (state DONE)
//  out_ready  in   1   consumer takes result
//  result     out  32  IEEE-754 sum
//  overflow   out  1   result rounded to +/-inf from finite operands
//  inexact    out  1   guard|sticky nonzero before rounding
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE; out_valid, result, overflow, inexact, busy = 0; in_ready = 1 on the following cycle.
//  - FSM: IDLE -> ALIGN -> ADD -> NORM (1+k cycles) -> ROUND -> DONE -> IDLE.
//    Specials bypass: IDLE -> DONE.
//  - Accept: in_valid & in_ready at IDLE.
//    - Unpack; denormal inputs flushed to zero.
//    - eop = sign_a ^ sign_b ^ op.
//    - Swap so that |A| >= |B|.
//    - Extended significand = {1'b0, hidden, frac, 24'b0}.
//    - Result sign = sign of the larger operand (b's sign is inverted when op = 1).
//  - ALIGN: B shifted right by d = expA - expB, saturated at 49.
//    - Shifted-out bits are ORed into bit 0 (sticky).
//  - ADD: one cycle through adder_eac.
//    - aSign tied 0 (swap guarantees aSig >= bSig).
//    - eop as computed.
//    - Sum registered.
//  - Exact cancellation (sum == 0 with eop = 1): result +0, inexact = 0. ROUND is skipped; NORM -> DONE.
//  - NORM: one step per cycle.
//    - bit48 set: shift right 1 (LSB into sticky), exp+1, leave.
//    - else bit47 set: leave.
//    - else: shift left 1, exp-1 (k = number of left shifts, k <= 25).
//    - exp reaching 0: flush to signed zero, -> DONE.
//  - ROUND (RNE): frac = bits[46:24], guard = bit23, sticky = |bits[22:0].
//    - Increment when guard & (sticky | lsb).
//    - Mantissa carry-out: exp+1.
//    - exp >= 255: result +/-inf, overflow = 1.
//  - Latency: out_valid rises 5+k clocks after the accept edge; specials take 1 clock.
//  - Specials:
//    - Any NaN, or inf - inf (effective): 0x7FC00000.
//    - Single inf: that inf with its effective sign.
//    - Zero + zero: sign per IEEE RNE (-0 only when both effective signs are negative).
//  - DONE: result/flags held stable while out_valid & !out_ready.
//    - On handshake -> IDLE; in_ready high the next cycle (no same-cycle re-accept).
//  - Inputs are ignored while busy.
//  - rst mid-operation aborts the op: out_valid = 0 after that edge, result is never emitted.
// STRUCTURE
//  - parameters.v (shared): SIG_WIDTH, EXP_WIDTH, BIAS, EXT_W = SIG_WIDTH*2+3, FSM state localparams, QNAN constant.
//  - Sub-modules:
//    - adder_eac: existing, instantiated as the ADD datapath.
//    - fp_round_rne: new, combinational; {frac, guard, sticky, exp} -> {frac, exp, ovf, inexact}.
//  - Single always block for FSM plus registered datapath; no other hierarchy.
// TESTING
//  1. 0x3F800000 + 0x3F800000, op=0 -> 0x40000000, k=0 (right-normalise), out_valid 5 clocks after accept.
//  2. 0x3F800000 - 0x3F800000 -> 0x00000000, inexact=0, overflow=0.
//  3. 0x3F800000 - 0x3F7FFFFF -> 0x33800000, k=24, out_valid exactly 29 clocks after accept.
//  4. 0x3F800000 + 0x33800000 (tie) -> 0x3F800000, inexact=1; 0x3F800001 + 0x33800000 -> 0x3F800002.
//  5. 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1.
//     0x7F800000 + 0xFF800000 -> 0x7FC00000, 1-clock latency.
//  6. Hold out_ready=0 for 6 clocks: result stable, in_ready=0, new in_valid ignored.
//     Assert rst during NORM: out_valid=0, busy=0 next cycle, next op correct.

Source files
------------

// File: rtl/fp_add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : fp_add_seq_pkg
// Brief  : Shared widths, constants and FSM states for the IEEE-754 single
//          precision add/sub sequencer and its datapath helpers.
// Rev    : 1.0 - initial release
// ============================================================================
package fp_add_seq_pkg;

  localparam int SIG_WIDTH = 23;                 // stored fraction bits
  localparam int EXP_WIDTH = 8;                  // exponent bits
  localparam int EXT_W     = SIG_WIDTH * 2 + 3;  // {ovf, hidden, frac, guard field}
  localparam int EXPQ_W    = EXP_WIDTH + 2;      // working exponent with headroom
  localparam int SHIFT_W   = 6;                  // holds alignment shifts up to EXT_W

  localparam logic [EXP_WIDTH-1:0] EXP_MAX = '1;
  localparam logic [31:0]          QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/adder_eac.sv
`default_nettype none
// ============================================================================
// Module : adder_eac
// Brief  : End-around-carry significand adder. Adds or subtracts magnitudes
//          and reports the sign of the result relative to operand A.
// Rev    : 1.0 - initial release
// ============================================================================
module adder_eac #(
  parameter int W = 49
) (
  input  logic [W-1:0] a_sig_i,
  input  logic [W-1:0] b_sig_i,
  input  logic         a_sign_i,
  input  logic         eop_i,
  output logic [W-1:0] sum_o,
  output logic         sign_o
);

  logic [W:0]   w_raw;
  logic [W-1:0] w_s;
  logic         w_c;

  assign w_raw = {1'b0, a_sig_i} + {1'b0, (eop_i ? ~b_sig_i : b_sig_i)};
  assign w_c   = w_raw[W];
  assign w_s   = w_raw[W-1:0];

  // Subtraction: carry out means A > B (add the end-around 1), otherwise complement
  always_comb begin
    sum_o  = w_s;
    sign_o = a_sign_i;
    if (eop_i) begin
      if (w_c) begin
        sum_o = w_s + W'(1);
      end else begin
        sum_o  = ~w_s;
        sign_o = ~a_sign_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_round_rne.sv
`default_nettype none
// ============================================================================
// Module : fp_round_rne
// Brief  : Combinational round-to-nearest-even of a normalised significand,
//          with exponent bump on mantissa carry and overflow to infinity.
// Rev    : 1.0 - initial release
// ============================================================================
module fp_round_rne
  import fp_add_seq_pkg::*;
(
  input  logic [SIG_WIDTH-1:0] frac_i,
  input  logic                 guard_i,
  input  logic                 sticky_i,
  input  logic [EXPQ_W-1:0]    exp_i,
  output logic [SIG_WIDTH-1:0] frac_o,
  output logic [EXP_WIDTH-1:0] exp_o,
  output logic                 ovf_o,
  output logic                 inexact_o
);

  logic                w_inc;
  logic [SIG_WIDTH:0]  w_sum;
  logic [EXPQ_W-1:0]   w_exp;

  assign w_inc     = guard_i & (sticky_i | frac_i[0]);
  assign w_sum     = {1'b0, frac_i} + (SIG_WIDTH + 1)'(w_inc);
  // A carry out of the fraction wraps it to zero and bumps the exponent
  assign w_exp     = exp_i + EXPQ_W'(w_sum[SIG_WIDTH]);
  assign ovf_o     = (w_exp >= {{(EXPQ_W - EXP_WIDTH){1'b0}}, EXP_MAX});
  assign exp_o     = ovf_o ? EXP_MAX : w_exp[EXP_WIDTH-1:0];
  assign frac_o    = ovf_o ? '0 : w_sum[SIG_WIDTH-1:0];
  assign inexact_o = guard_i | sticky_i;

endmodule
`default_nettype wire

// File: rtl/fp_add_seq.sv
`default_nettype none
// ============================================================================
// Module : fp_add_seq
// Brief  : Multi-cycle IEEE-754 single precision add/sub sequencer with
//          valid/ready handshakes, one operation in flight, RNE rounding.
// Rev    : 1.0 - initial release
// ============================================================================
module fp_add_seq
  import fp_add_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        inexact,
  output logic        busy
);

  localparam int FB = SIG_WIDTH;  // lsb of the exponent field in the word

  // ---- unpack (denormals flushed to zero) ---------------------------------
  logic                 w_sa, w_sb;
  logic [EXP_WIDTH-1:0] w_ea, w_eb;
  logic [SIG_WIDTH-1:0] w_fa, w_fb;
  logic                 w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;

  assign w_sa     = a[31];
  assign w_sb     = b[31] ^ op;
  assign w_ea     = a[FB +: EXP_WIDTH];
  assign w_eb     = b[FB +: EXP_WIDTH];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_fa     = w_a_zero ? '0 : a[SIG_WIDTH-1:0];
  assign w_fb     = w_b_zero ? '0 : b[SIG_WIDTH-1:0];
  assign w_a_inf  = (w_ea == EXP_MAX) && (a[SIG_WIDTH-1:0] == '0);
  assign w_b_inf  = (w_eb == EXP_MAX) && (b[SIG_WIDTH-1:0] == '0);
  assign w_a_nan  = (w_ea == EXP_MAX) && (a[SIG_WIDTH-1:0] != '0);
  assign w_b_nan  = (w_eb == EXP_MAX) && (b[SIG_WIDTH-1:0] != '0);

  // ---- swap so the larger magnitude is A ----------------------------------
  logic                 w_eop, w_swap, w_big_sign, w_big_zero, w_small_zero;
  logic [EXP_WIDTH-1:0] w_big_e, w_small_e, w_diff;
  logic [SIG_WIDTH-1:0] w_big_f, w_small_f;
  logic [EXT_W-1:0]     w_big_ext, w_small_ext;
  logic [SHIFT_W-1:0]   w_d;

  assign w_eop        = w_sa ^ w_sb;
  assign w_swap       = {w_eb, w_fb} > {w_ea, w_fa};
  assign w_big_sign   = w_swap ? w_sb : w_sa;
  assign w_big_zero   = w_swap ? w_b_zero : w_a_zero;
  assign w_small_zero = w_swap ? w_a_zero : w_b_zero;
  assign w_big_e      = w_swap ? w_eb : w_ea;
  assign w_small_e    = w_swap ? w_ea : w_eb;
  assign w_big_f      = w_swap ? w_fb : w_fa;
  assign w_small_f    = w_swap ? w_fa : w_fb;
  assign w_big_ext    = {1'b0, ~w_big_zero, w_big_f, {(SIG_WIDTH + 1){1'b0}}};
  assign w_small_ext  = {1'b0, ~w_small_zero, w_small_f, {(SIG_WIDTH + 1){1'b0}}};
  assign w_diff       = w_big_e - w_small_e;
  assign w_d          = (w_diff > EXP_WIDTH'(EXT_W)) ? SHIFT_W'(EXT_W) : w_diff[SHIFT_W-1:0];

  // ---- special operands resolve immediately -------------------------------
  logic        w_special;
  logic [31:0] w_special_res;

  // NaN / infinity / double-zero cases that never touch the datapath
  always_comb begin
    w_special     = 1'b1;
    w_special_res = QNAN;
    if (w_a_nan || w_b_nan) begin
      w_special_res = QNAN;
    end else if (w_a_inf && w_b_inf) begin
      w_special_res = w_eop ? QNAN : {w_sa, EXP_MAX, {SIG_WIDTH{1'b0}}};
    end else if (w_a_inf) begin
      w_special_res = {w_sa, EXP_MAX, {SIG_WIDTH{1'b0}}};
    end else if (w_b_inf) begin
      w_special_res = {w_sb, EXP_MAX, {SIG_WIDTH{1'b0}}};
    end else if (w_a_zero && w_b_zero) begin
      w_special_res = {w_sa & w_sb, 31'b0};
    end else begin
      w_special = 1'b0;
    end
  end

  // ---- state and datapath registers ---------------------------------------
  state_e             state_q;
  logic               in_ready_q, out_valid_q, busy_q, overflow_q, inexact_q;
  logic [31:0]        result_q;
  logic               sign_q, eop_q;
  logic [EXPQ_W-1:0]  exp_q;
  logic [EXT_W-1:0]   siga_q, sigb_q;
  logic [SHIFT_W-1:0] d_q;

  // ---- align: right shift with shifted-out bits folded into bit 0 ---------
  logic [EXT_W-1:0] w_mask, w_align;

  assign w_mask  = ~({EXT_W{1'b1}} << d_q);
  assign w_align = (sigb_q >> d_q) | {{(EXT_W - 1){1'b0}}, |(sigb_q & w_mask)};

  // ---- add / round datapath ------------------------------------------------
  logic [EXT_W-1:0]     w_sum;
  logic                 w_add_sign;
  logic [SIG_WIDTH-1:0] w_rnd_frac;
  logic [EXP_WIDTH-1:0] w_rnd_exp;
  logic                 w_rnd_ovf, w_rnd_inx;

  adder_eac #(.W(EXT_W)) u_adder (
    .a_sig_i  (siga_q),
    .b_sig_i  (sigb_q),
    .a_sign_i (1'b0),
    .eop_i    (eop_q),
    .sum_o    (w_sum),
    .sign_o   (w_add_sign)
  );

  fp_round_rne u_round (
    .frac_i    (siga_q[2*SIG_WIDTH:SIG_WIDTH+1]),
    .guard_i   (siga_q[SIG_WIDTH]),
    .sticky_i  (|siga_q[SIG_WIDTH-1:0]),
    .exp_i     (exp_q),
    .frac_o    (w_rnd_frac),
    .exp_o     (w_rnd_exp),
    .ovf_o     (w_rnd_ovf),
    .inexact_o (w_rnd_inx)
  );

  // Sequencer FSM plus the registered significand/exponent datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      inexact_q   <= 1'b0;
      sign_q      <= 1'b0;
      eop_q       <= 1'b0;
      exp_q       <= '0;
      siga_q      <= '0;
      sigb_q      <= '0;
      d_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (w_special) begin
              result_q    <= w_special_res;
              overflow_q  <= 1'b0;
              inexact_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              sign_q  <= w_big_sign;
              eop_q   <= w_eop;
              exp_q   <= {{(EXPQ_W - EXP_WIDTH){1'b0}}, w_big_e};
              siga_q  <= w_big_ext;
              sigb_q  <= w_small_ext;
              d_q     <= w_d;
              state_q <= S_ALIGN;
            end
          end
        end
        S_ALIGN: begin
          sigb_q  <= w_align;
          state_q <= S_ADD;
        end
        S_ADD: begin
          siga_q  <= w_sum;
          sign_q  <= sign_q ^ w_add_sign;
          state_q <= S_NORM;
        end
        S_NORM: begin
          if (eop_q && (siga_q == '0)) begin
            // exact cancellation is always +0 under round-to-nearest
            result_q    <= '0;
            overflow_q  <= 1'b0;
            inexact_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (siga_q[EXT_W-1]) begin
            siga_q  <= {1'b0, siga_q[EXT_W-1:2], siga_q[1] | siga_q[0]};
            exp_q   <= exp_q + EXPQ_W'(1);
            state_q <= S_ROUND;
          end else if (siga_q[EXT_W-2]) begin
            state_q <= S_ROUND;
          end else if (exp_q <= EXPQ_W'(1)) begin
            // one more left shift would leave the normal range: flush
            result_q    <= {sign_q, 31'b0};
            overflow_q  <= 1'b0;
            inexact_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            siga_q <= {siga_q[EXT_W-2:0], 1'b0};
            exp_q  <= exp_q - EXPQ_W'(1);
          end
        end
        S_ROUND: begin
          result_q    <= {sign_q, w_rnd_exp, w_rnd_frac};
          overflow_q  <= w_rnd_ovf;
          inexact_q   <= w_rnd_inx;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign inexact   = inexact_q;

endmodule
`default_nettype wire
